// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line widths and the L1/L2 arbiter state encoding.
// Used by l1_l2_arbiter and l1_l2_arbiter_control.
package lc3b_types;

    localparam int LC3B_WORD_WIDTH = 16;
    localparam int LC3B_LINE_WIDTH = 128;

    typedef logic [LC3B_WORD_WIDTH-1:0] lc3b_word;
    typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_c_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } lc3b_arb_grant;

endpackage

// File: rtl/l1_l2_arbiter_control.sv
// Arbiter FSM: picks a cache from IDLE, waits for l2_resp, pulses the winner's resp.
// Optional ARB_ROUND_ROBIN_EN: collisions go to the cache not granted most recently.
module l1_l2_arbiter_control
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          icache_req_i,
    input  logic          dcache_req_i,
    input  logic          l2_resp_i,
    output lc3b_arb_state state_o,
    output logic          grant_i_o,
    output logic          grant_d_o,
    output logic          icache_resp_o,
    output logic          dcache_resp_o
);

    lc3b_arb_state state_q, state_d;
    logic          prefer_d;

`ifdef ARB_ROUND_ROBIN_EN
    lc3b_arb_grant last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_d_o)      last_grant_d = GRANT_D;
        else if (grant_i_o) last_grant_d = GRANT_I;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= GRANT_I;
        else        last_grant_q <= last_grant_d;
    end

    assign prefer_d = (last_grant_q == GRANT_I);
`else
    assign prefer_d = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        grant_i_o     = 1'b0;
        grant_d_o     = 1'b0;
        icache_resp_o = 1'b0;
        dcache_resp_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dcache_req_i && (!icache_req_i || prefer_d)) begin
                    grant_d_o = 1'b1;
                    state_d   = SERVE_D;
                end else if (icache_req_i) begin
                    grant_i_o = 1'b1;
                    state_d   = SERVE_I;
                end
            end
            SERVE_I: begin
                icache_resp_o = l2_resp_i;
                if (l2_resp_i) state_d = IDLE;
            end
            SERVE_D: begin
                dcache_resp_o = l2_resp_i;
                if (l2_resp_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares one L2 port between the L1 I-cache and D-cache; datapath holding registers live here.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin collision handling (default: D-cache wins).
module l1_l2_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = LC3B_WORD_WIDTH,
    parameter int LINE_WIDTH = LC3B_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    lc3b_arb_state             state;
    logic                      grant_i, grant_d, busy;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [LINE_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      write_q, write_d;

    l1_l2_arbiter_control u_control (
        .clk           (clk),
        .rst_n         (rst_n),
        .icache_req_i  (icache_read),
        .dcache_req_i  (dcache_read | dcache_write),
        .l2_resp_i     (l2_resp),
        .state_o       (state),
        .grant_i_o     (grant_i),
        .grant_d_o     (grant_d),
        .icache_resp_o (icache_resp),
        .dcache_resp_o (dcache_resp)
    );

    // A simultaneous D read+write is taken as a writeback.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        if (grant_d) begin
            addr_d  = dcache_address;
            wdata_d = dcache_wdata;
            write_d = dcache_write;
        end else if (grant_i) begin
            addr_d  = icache_address;
            wdata_d = '0;
            write_d = 1'b0;
        end
    end

    // NOTE: holding registers are reset so the L2 port shows a clean zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    assign busy       = (state != IDLE);
    assign l2_read    = busy & ~write_q;
    assign l2_write   = busy &  write_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;

    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_l1_l2_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          icache_read;
    logic [AW-1:0] icache_address;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic          dcache_read, dcache_write;
    logic [AW-1:0] dcache_address;
    logic [LW-1:0] dcache_wdata, dcache_rdata;
    logic          dcache_resp;
    logic          l2_read, l2_write;
    logic [AW-1:0] l2_address;
    logic [LW-1:0] l2_wdata, l2_rdata;
    logic          l2_resp;

    always #5 clk = ~clk;

    l1_l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_address     (l2_address),
        .l2_wdata       (l2_wdata),
        .l2_rdata       (l2_rdata),
        .l2_resp        (l2_resp)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the L2 port and which transaction was accepted.
    typedef enum int {NONE, OWN_I, OWN_D} owner_e;
    owner_e        owner;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic          m_write;
    bit            last_was_d;

    int cnt_rd, cnt_wr, cnt_iresp, cnt_dresp;
    bit seen_iresp, seen_dresp;

    function automatic bit model_prefer_d();
`ifdef ARB_ROUND_ROBIN_EN
        return !last_was_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        owner      = NONE;
        last_was_d = 1'b0;
    endtask

    task automatic clr_counts();
        cnt_rd = 0; cnt_wr = 0; cnt_iresp = 0; cnt_dresp = 0;
    endtask

    // Transaction rules at a clock edge, using the inputs presented to that edge.
    task automatic model_step();
        bit d_req;
        if (owner != NONE) begin
            if (l2_resp) owner = NONE;
        end else begin
            d_req = dcache_read | dcache_write;
            if (d_req && (!icache_read || model_prefer_d())) begin
                owner = OWN_D; m_addr = dcache_address; m_wdata = dcache_wdata;
                m_write = dcache_write; last_was_d = 1'b1;
            end else if (icache_read) begin
                owner = OWN_I; m_addr = icache_address; m_write = 1'b0; last_was_d = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        bit busy;
        busy = (owner != NONE);
        check("l2_read", l2_read, busy && !m_write);
        check("l2_write", l2_write, busy && m_write);
        if (busy) check("l2_address", l2_address, m_addr);
        if (busy && m_write) check("l2_wdata", l2_wdata, m_wdata);
        check("icache_resp", icache_resp, (owner == OWN_I) && l2_resp);
        check("dcache_resp", dcache_resp, (owner == OWN_D) && l2_resp);
        check("icache_rdata", icache_rdata, l2_rdata);
        check("dcache_rdata", dcache_rdata, l2_rdata);
        seen_iresp = icache_resp;
        seen_dresp = dcache_resp;
        if (l2_read)     cnt_rd++;
        if (l2_write)    cnt_wr++;
        if (icache_resp) cnt_iresp++;
        if (dcache_resp) cnt_dresp++;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        l2_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic collide(input string tag);
        int order[$];
        int exp_first;
        int waited;
        exp_first = model_prefer_d() ? 2 : 1;
        icache_read = 1'b1; icache_address = AW'($urandom);
        dcache_read = 1'b1; dcache_write = 1'b0; dcache_address = AW'($urandom);
        l2_resp = 1'b0;
        waited = 0;
        while (order.size() < 2 && waited < 40) begin
            cycle();
            waited++;
            if (seen_iresp) begin order.push_back(1); icache_read = 1'b0; end
            if (seen_dresp) begin order.push_back(2); dcache_read = 1'b0; end
            l2_resp = 1'($urandom_range(0, 1));
        end
        l2_resp = 1'b0; icache_read = 1'b0; dcache_read = 1'b0;
        check({tag, "_served"}, order.size(), 2);
        if (order.size() == 2) begin
            check({tag, "_first"}, order[0], exp_first);
            check({tag, "_second"}, order[1], 3 - exp_first);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit i_out, d_out;
        int dtype;

        rst_n = 1'b0;
        icache_read = 1'b0; icache_address = '0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = '0; dcache_wdata = '0;
        l2_rdata = '0; l2_resp = 1'b0;
        model_reset();
        clr_counts();

        // Reset values
        #2;
        check("rst_l2_read", l2_read, 1'b0);
        check("rst_l2_write", l2_write, 1'b0);
        check("rst_l2_address", l2_address, '0);
        check("rst_l2_wdata", l2_wdata, '0);
        @(negedge clk);
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // I-cache read, L2 answers on the 4th strobe cycle
        clr_counts();
        icache_read = 1'b1; icache_address = 16'h1230; l2_resp = 1'b0;
        cycle();
        repeat (3) cycle();
        l2_resp = 1'b1; l2_rdata = {16{8'hA5}};
        @(negedge clk);
        check("s1_icache_rdata", icache_rdata, {16{8'hA5}});
        check("s1_icache_resp", icache_resp, 1'b1);
        check_outputs(); model_step(); @(posedge clk); #1;
        icache_read = 1'b0; l2_resp = 1'b0;
        cycle();
        check("s1_read_cycles", cnt_rd, 4);
        check("s1_iresp_pulses", cnt_iresp, 1);
        check("s1_dresp_pulses", cnt_dresp, 0);

        // D-cache writeback with address/data changing mid-transaction
        clr_counts();
        dcache_write = 1'b1; dcache_address = 16'h4560; dcache_wdata = {16{8'h0F}};
        cycle();
        dcache_address = 16'hFFF0; dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) cycle();
        check("s2_hold_address", l2_address, 16'h4560);
        check("s2_hold_wdata", l2_wdata, {16{8'h0F}});
        l2_resp = 1'b1;
        cycle();
        dcache_write = 1'b0; l2_resp = 1'b0;
        cycle();
        check("s2_write_cycles", cnt_wr, 3);
        check("s2_read_cycles", cnt_rd, 0);
        check("s2_dresp_pulses", cnt_dresp, 1);

        // Collisions
        collide("col1");
        collide("col2");

        // Reset pulse while serving the I-cache, L2 never answers
        clr_counts();
        icache_read = 1'b1; icache_address = 16'h2222; l2_resp = 1'b0;
        repeat (2) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("s4_l2_read_async", l2_read, 1'b0);
        check("s4_iresp_async", icache_resp, 1'b0);
        model_reset();
        icache_read = 1'b0; dcache_read = 1'b1; dcache_address = 16'h3330;
        @(negedge clk);
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("s4_iresp_pulses", cnt_iresp, 0);
        clr_counts();
        cycle();
        l2_resp = 1'b1;
        cycle();
        dcache_read = 1'b0; l2_resp = 1'b0;
        cycle();
        check("s4_d_read_cycles", cnt_rd, 1);
        check("s4_dresp_pulses", cnt_dresp, 1);
        check("s4_iresp_after", cnt_iresp, 0);

        // Stray l2_resp in IDLE
        clr_counts();
        l2_resp = 1'b1;
        repeat (3) cycle();
        l2_resp = 1'b0;
        cycle();
        check("s5_resp_pulses", cnt_iresp + cnt_dresp, 0);
        check("s5_strobe_cycles", cnt_rd + cnt_wr, 0);

        // Read and write together is a write
        clr_counts();
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h0AB0;
        dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) cycle();
        l2_resp = 1'b1;
        cycle();
        dcache_read = 1'b0; dcache_write = 1'b0; l2_resp = 1'b0;
        cycle();
        check("s6_read_cycles", cnt_rd, 0);
        check("s6_write_cycles", cnt_wr, 2);

        // Randomized traffic
        i_out = 1'b0; d_out = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (seen_iresp) i_out = 1'b0;
            if (seen_dresp) d_out = 1'b0;
            if (!i_out && $urandom_range(0, 2) == 0) begin
                i_out = 1'b1; icache_read = 1'b1; icache_address = AW'($urandom);
            end else if (i_out && owner == OWN_I && $urandom_range(0, 3) == 0) begin
                icache_read = 1'($urandom_range(0, 1)); icache_address = AW'($urandom);
            end else if (!i_out) begin
                icache_read = 1'b0;
            end
            if (!d_out && $urandom_range(0, 2) == 0) begin
                d_out = 1'b1; dtype = $urandom_range(0, 2);
                dcache_read = (dtype != 1); dcache_write = (dtype != 0);
                dcache_address = AW'($urandom);
                dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (d_out && owner == OWN_D && $urandom_range(0, 3) == 0) begin
                dcache_read = 1'($urandom_range(0, 1)); dcache_write = 1'($urandom_range(0, 1));
                dcache_address = AW'($urandom);
                dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (!d_out) begin
                dcache_read = 1'b0; dcache_write = 1'b0;
            end
            l2_resp = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
